// File: rtl/r5p_button_reset_debounce.sv
// r5p_button_reset_debounce
// Board-side input conditioner: synchronizes and debounces push-buttons into
// clean level/press/release signals, and turns one selected button into an
// active-high SoC reset that asserts asynchronously and releases synchronously.

module r5p_button_reset_debounce #(
    parameter int unsigned BTN_NUM = 2,
    parameter logic        BTN_POL = 1'b0,
    parameter int unsigned DEB_CNT = 270000,
    parameter int unsigned RST_BTN = 0,
    parameter int unsigned RST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BTN_NUM-1:0] btn_i,
    output logic [BTN_NUM-1:0] btn_o,
    output logic [BTN_NUM-1:0] btn_p,
    output logic [BTN_NUM-1:0] btn_r,
    output logic               rst_o
);

    // DEB_CNT >= 1, RST_LEN >= 1 and RST_BTN < BTN_NUM are assumed by the
    // counter widths and compare values below.
    localparam int unsigned CW = $clog2(DEB_CNT + 1);
    localparam int unsigned HW = $clog2(RST_LEN + 1);

    localparam logic [CW-1:0]      DEB_LAST  = CW'(DEB_CNT - 1);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(RST_LEN - 1);
    localparam logic [BTN_NUM-1:0] IDLE_PINS = {BTN_NUM{~BTN_POL}};

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } rst_state_t;

    logic [BTN_NUM-1:0] sync1;
    logic [BTN_NUM-1:0] sync2;
    logic [BTN_NUM-1:0] sample;
    logic [CW-1:0]      deb_cnt [BTN_NUM];

    rst_state_t         state;
    rst_state_t         state_next;
    logic [HW-1:0]      hold_cnt;
    logic [HW-1:0]      hold_cnt_next;
    logic               rst_btn;

    // Two-flop synchronizer; comes out of reset reading "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_PINS;
            sync2 <= IDLE_PINS;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
        end
    end

    // Normalize polarity so that 1 always means "pressed".
    assign sample = sync2 ^ IDLE_PINS;

    // Per-button debounce: accept a change only after DEB_CNT consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_o <= '0;
            btn_p <= '0;
            btn_r <= '0;
            for (int i = 0; i < int'(BTN_NUM); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            btn_p <= '0;
            btn_r <= '0;
            for (int i = 0; i < int'(BTN_NUM); i++) begin
                if (sample[i] == btn_o[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    btn_o[i]   <= ~btn_o[i];
                    btn_p[i]   <= ~btn_o[i];
                    btn_r[i]   <= btn_o[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rst_btn = btn_o[RST_BTN];

    // Reset FSM next-state: HOLD counts RST_LEN quiet cycles before RUN;
    // a debounced press of the reset button returns to HOLD.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            HOLD: begin
                if (rst_btn) begin
                    hold_cnt_next = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next    = RUN;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HW'(1);
                end
            end
            RUN: begin
                if (rst_btn) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next    = HOLD;
                hold_cnt_next = '0;
            end
        endcase
    end

    // State register; rst_o is its own flop so the SoC never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HOLD;
            hold_cnt <= '0;
            rst_o    <= 1'b1;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            rst_o    <= (state_next == HOLD);
        end
    end

endmodule

// File: tb/tb_r5p_button_reset_debounce.sv
// tb_r5p_button_reset_debounce
// Self-checking bench: a table of power-up/press/release vectors, hand-written
// glitch/reset-button/bounce/async-reset sequences, then randomized pin activity,
// all compared every cycle against a history-based reference model.

module tb_r5p_button_reset_debounce;

    localparam int N   = 2;
    localparam int D   = 4;
    localparam int L   = 3;
    localparam int RB  = 0;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn_i;
    logic [N-1:0] btn_o;
    logic [N-1:0] btn_p;
    logic [N-1:0] btn_r;
    logic         rst_o;

    int passCount;
    int checkCount;

    r5p_button_reset_debounce #(
        .BTN_NUM(N),
        .BTN_POL(1'b0),
        .DEB_CNT(D),
        .RST_BTN(RB),
        .RST_LEN(L)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_i(btn_i),
        .btn_o(btn_o),
        .btn_p(btn_p),
        .btn_r(btn_r),
        .rst_o(rst_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pins reach the debouncer two edges late; a button's
    // state flips once its last D samples all disagree with it; the reset is
    // released once the reset button has been seen idle on L consecutive edges.
    logic [N-1:0] mPinDly [2];
    logic [D-1:0] mHist [N];
    logic [N-1:0] mState;
    logic [N-1:0] mPress;
    logic [N-1:0] mRel;
    int           mQuiet;
    logic         mRst;

    always @(posedge clk or negedge rst_n) begin : refModel
        logic [N-1:0] smp;
        logic [N-1:0] st;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [D-1:0] h;
        int           q;
        if (!rst_n) begin
            mPinDly[0] <= '1;
            mPinDly[1] <= '1;
            for (int b = 0; b < N; b++) mHist[b] <= '0;
            mState <= '0;
            mPress <= '0;
            mRel   <= '0;
            mQuiet <= 0;
            mRst   <= 1'b1;
        end else begin
            smp = ~mPinDly[1];
            st  = mState;
            pr  = '0;
            rl  = '0;
            for (int b = 0; b < N; b++) begin
                h = {mHist[b][D-2:0], smp[b]};
                mHist[b] <= h;
                if (h == {D{~mState[b]}}) begin
                    st[b] = ~mState[b];
                    pr[b] = st[b];
                    rl[b] = ~st[b];
                end
            end
            q = mQuiet;
            if (mState[RB]) q = 0;
            else if (q < L) q = q + 1;
            mQuiet     <= q;
            mRst       <= (q < L);
            mState     <= st;
            mPress     <= pr;
            mRel       <= rl;
            mPinDly[1] <= mPinDly[0];
            mPinDly[0] <= btn_i;
        end
    end

    typedef struct {
        logic         rstn;
        logic [N-1:0] pins;
        logic [N-1:0] expO;
        logic [N-1:0] expP;
        logic [N-1:0] expR;
        logic         expRst;
    } vec_t;

    vec_t vecs [17];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic rstn, input logic [N-1:0] pins);
        rst_n = rstn;
        btn_i = pins;
    endtask

    // One clock edge, then compare every output against the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput("model btn_o", 32'(btn_o), 32'(mState));
        checkOutput("model btn_p", 32'(btn_p), 32'(mPress));
        checkOutput("model btn_r", 32'(btn_r), 32'(mRel));
        checkOutput("model rst_o", 32'(rst_o), 32'(mRst));
    endtask

    initial begin : stimulus
        int highs;
        int pCnt;
        int rCnt;
        int btnRise, btnFall, rstRise, rstFall;
        logic prevB, prevR;
        logic [N-1:0] pins;

        passCount  = 0;
        checkCount = 0;

        // Power-up, press btn1, release btn1: expected values written out per edge.
        for (int i = 0; i < 17; i++) begin
            vecs[i].rstn   = 1'b1;
            vecs[i].pins   = (i >= 3 && i < 10) ? 2'b01 : 2'b11;
            vecs[i].expO   = (i >= 8 && i < 15) ? 2'b10 : 2'b00;
            vecs[i].expP   = (i == 8)  ? 2'b10 : 2'b00;
            vecs[i].expR   = (i == 15) ? 2'b10 : 2'b00;
            vecs[i].expRst = (i < 2);
        end

        applyStimulus(1'b0, 2'b11);
        repeat (3) @(negedge clk);
        checkOutput("reset btn_o", 32'(btn_o), 32'h0);
        checkOutput("reset btn_p", 32'(btn_p), 32'h0);
        checkOutput("reset btn_r", 32'(btn_r), 32'h0);
        checkOutput("reset rst_o", 32'(rst_o), 32'h1);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].pins);
            tick();
            checkOutput($sformatf("vec%0d btn_o", i), 32'(btn_o), 32'(vecs[i].expO));
            checkOutput($sformatf("vec%0d btn_p", i), 32'(btn_p), 32'(vecs[i].expP));
            checkOutput($sformatf("vec%0d btn_r", i), 32'(btn_r), 32'(vecs[i].expR));
            checkOutput($sformatf("vec%0d rst_o", i), 32'(rst_o), 32'(vecs[i].expRst));
        end

        // A 3-cycle glitch on btn1 must be rejected.
        highs = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, (i < 3) ? 2'b01 : 2'b11);
            tick();
            if (btn_o[1] || btn_p[1]) highs++;
        end
        checkOutput("glitch3 rejected", 32'(highs), 32'h0);

        // A 4-cycle glitch is long enough to register as a press and release.
        pCnt = 0;
        rCnt = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, (i < 4) ? 2'b01 : 2'b11);
            tick();
            if (btn_p[1]) pCnt++;
            if (btn_r[1]) rCnt++;
        end
        checkOutput("glitch4 press", 32'(pCnt), 32'h1);
        checkOutput("glitch4 release", 32'(rCnt), 32'h1);

        // Reset button held 10 cycles while running.
        pCnt = 0; rCnt = 0;
        btnRise = -100; btnFall = -100; rstRise = -100; rstFall = -100;
        prevB = btn_o[0];
        prevR = rst_o;
        for (int t = 0; t < 24; t++) begin
            applyStimulus(1'b1, (t < 10) ? 2'b10 : 2'b11);
            tick();
            if (btn_o[0] && !prevB) btnRise = t;
            if (!btn_o[0] && prevB) btnFall = t;
            if (rst_o && !prevR) rstRise = t;
            if (!rst_o && prevR) rstFall = t;
            if (btn_p[0]) pCnt++;
            if (btn_r[0]) rCnt++;
            prevB = btn_o[0];
            prevR = rst_o;
        end
        checkOutput("rstbtn press seen", 32'(btnRise), 32'd5);
        checkOutput("rst_o rise lag", 32'(rstRise - btnRise), 32'd1);
        checkOutput("rst_o fall lag", 32'(rstFall - btnFall), 32'd3);
        checkOutput("rstbtn press pulses", 32'(pCnt), 32'h1);
        checkOutput("rstbtn release pulses", 32'(rCnt), 32'h1);

        // Bouncing reset button: two cycles each level must never get through.
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, (((i / 2) % 2) == 0) ? 2'b10 : 2'b11);
            tick();
            if (btn_o[0] || rst_o) highs++;
        end
        checkOutput("bounce rejected", 32'(highs), 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'b11);
            tick();
        end

        // Async reset while btn1 is pressed and btn0 is mid-count.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'b01);
            tick();
        end
        checkOutput("pre-reset btn_o", 32'(btn_o), 32'h2);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'b00);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async btn_o", 32'(btn_o), 32'h0);
        checkOutput("async rst_o", 32'(rst_o), 32'h1);
        checkOutput("async btn_r", 32'(btn_r), 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 2'b01);
        rCnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 3) checkOutput($sformatf("rerelease rst_o e%0d", i), 32'(rst_o), (i < 2) ? 32'h1 : 32'h0);
            if (btn_r != '0) rCnt++;
        end
        checkOutput("no release after reset", 32'(rCnt), 32'h0);

        // Randomized pin activity with occasional short resets.
        for (int seg = 0; seg < 80; seg++) begin
            pins = N'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(1'b0, pins);
                tick();
            end
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
                applyStimulus(1'b1, pins);
                tick();
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/r5p_button_reset_debounce.md
Name: r5p_button_reset_debounce

Overview:
- Input-side board conditioner for the Gowin board tops: synchronizes and debounces the push-buttons, then produces clean level and edge signals.
- One selected button drives a system reset for the SoC. The reset asserts asynchronously and releases synchronously.
- Sits between the board button pins and the SoC `clk`/`rst` inputs. Replaces the direct button-to-reset wiring.

Parameters:
- BTN_NUM, 2, number of buttons.
- BTN_POL, 1'b0, pin level meaning "pressed" (0 = active-low pins, as on Tang Nano 9k).
- DEB_CNT, 270000, consecutive stable samples needed to accept a change (10 ms at 27 MHz). Must be ≥1.
- RST_BTN, 0, index of the button that drives `rst_o`. Must be < BTN_NUM.
- RST_LEN, 16, `rst_o` hold cycles after reset release. Must be ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset (power-on / PLL-lock).
- btn_i  input  BTN_NUM  raw button pins, asynchronous.
- btn_o  output  BTN_NUM  debounced state, 1 = pressed (polarity normalized).
- btn_p  output  BTN_NUM  one-cycle pulse on debounced press.
- btn_r  output  BTN_NUM  one-cycle pulse on debounced release.
- rst_o  output  1  active-high SoC reset: asynchronous assert, synchronous release.

Behaviour:
- One clock and one reset domain: clk, with async active-low rst_n. All flops reset asynchronously by rst_n.
- Reset values:
  - sync flops = ~BTN_POL (not pressed)
  - btn_o = 0, btn_p = 0, btn_r = 0
  - debounce counters = 0
  - rst_o = 1, FSM = HOLD, hold counter = 0
- Synchronizer: 2 flops per bit. Normalized sample s = sync2 ^ ~BTN_POL, so 1 = pressed.
- Debounce, per button, independent:
  - Counter width = $clog2(DEB_CNT+1).
  - If s == btn_o: counter cleared.
  - If s != btn_o and counter == DEB_CNT-1: btn_o toggles, counter cleared. Same edge sets btn_p (0→1 toggle) or btn_r (1→0 toggle) for exactly one cycle.
  - Otherwise counter increments.
  - A change is accepted only after DEB_CNT consecutive differing samples. Any agreeing sample restarts the count (glitch rejection).
  - Latency from pin edge to btn_o: 2 sync cycles + DEB_CNT cycles, ±1 for pin phase.
  - btn_p and btn_r are never both high for one button. Pulses are registered.
- Reset FSM, states HOLD and RUN:
  - HOLD, rst_o = 1:
    - If btn_o[RST_BTN] = 1: hold counter cleared, stay in HOLD.
    - Else: counter increments. When counter == RST_LEN-1, go to RUN; rst_o = 0 from the next cycle.
    - After rst_n release with the button not pressed, rst_o stays high for exactly RST_LEN clk cycles.
  - RUN, rst_o = 0: btn_o[RST_BTN] = 1 → HOLD, counter cleared, rst_o = 1 the next cycle.
  - btn_o[RST_BTN] is debounced, so a bounce cannot toggle rst_o.
  - rst_o is a direct flop output, not combinational from rst_n decode. rst_n low forces rst_o = 1 immediately (async).
- Button held through power-up: btn_o starts at 0. After 2+DEB_CNT cycles, btn_p fires and btn_o = 1. The reset FSM may have entered RUN if RST_LEN < 2+DEB_CNT; it then returns to HOLD. This is accepted behaviour.
- rst_n asserted mid-operation: all state returns to reset values instantly. No pulses are emitted on the reset edge.
- Non-reset buttons have no effect on rst_o.

Test Plan (DEB_CNT=4, RST_LEN=3, BTN_NUM=2, BTN_POL=0, RST_BTN=0):
- Power-up, btn_i = 2'b11 (released): rst_n low then high at edge 0 → rst_o = 1 for edges 0..2, 0 from edge 3. btn_o = 0, no pulses.
- btn_i[1] 1→0 and held → btn_o[1] = 1 after 2+4 cycles, btn_p[1] high exactly one cycle. Release → btn_r[1] one cycle after the same delay. rst_o stays 0 throughout.
- btn_i[1] glitches low for 3 cycles, then high → btn_o[1] stays 0, no pulse. A 4-cycle glitch → press accepted.
- In RUN, btn_i[0] low and held 10 cycles, then released → rst_o rises one cycle after btn_o[0] rises. It falls 3 cycles after btn_o[0] falls. btn_p[0] and btn_r[0] each pulse once.
- Bouncing btn_i[0] (alternating every 2 cycles for 20 cycles) → btn_o[0] never changes, rst_o stays 0.
- rst_n pulsed low while btn_o[1] = 1 and counters mid-count → btn_o = 0 and rst_o = 1 immediately. No btn_r pulse. Normal RST_LEN release follows.
